serial_adder: RTL and testbench

Bit-serial adder with carry-in: adds two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It is the addition counterpart to the team's full-subtractor cell. It sits in the combinational/arithmetic library as the sequential, area-minimal alternative to a ripple adder. A start/busy/done handshake brackets each operation.

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop add two WIDTH-bit
// operands LSB first, bracketed by a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CW-1:0]    cnt_reg;

  logic s_bit;
  logic carry_next;

  always_comb begin
    s_bit      = a_reg[0] ^ b_reg[0] ^ carry_reg;
    carry_next = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          acc_reg   <= {s_bit, acc_reg[WIDTH-1:1]};
          carry_reg <= carry_next;
          cnt_reg   <= cnt_reg + 1'b1;
          // Final bit: publish the whole word at once so no partial sum is visible.
          if (cnt_reg == CW'(WIDTH - 1)) begin
            sum_reg   <= {s_bit, acc_reg[WIDTH-1:1]};
            cout_reg  <= carry_next;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, random ops against an
// arithmetic model, exhaustive 2-bit sweep and handshake corner sequences.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, cin8, cout8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, cout2, busy2, done2;
  logic [1:0] a2, b2, sum2;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one WIDTH=8 operation; checks latency, busy length, stability and result.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input logic [8:0] expv, input string tag);
    logic [8:0] prev;
    int k, busy_cnt;
    bit seen;
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    prev = {cout8, sum8};
    busy_cnt = busy8 ? 1 : 0;
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (busy8) busy_cnt++;
      if (done8) begin
        k = i;
        seen = 1'b1;
        break;
      end
      if ({cout8, sum8} !== prev) chk({tag, "_stable"}, {23'd0, cout8, sum8}, {23'd0, prev});
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_latency"}, k, 8);
    chk({tag, "_busy_cycles"}, busy_cnt, 9);
    chk({tag, "_result"}, {23'd0, cout8, sum8}, {23'd0, expv});
    tick();
    chk({tag, "_done_low"}, {30'd0, done8, busy8}, 32'd0);
    $display("op8 %s a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h", tag, ta, tb, tc, cout8, sum8);
  endtask

  initial begin
    logic [8:0]  model;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [16:0] hist[40];
    int          dcount;
    bit          seen;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    tick(); tick();
    chk("reset8", {21'd0, sum8, cout8, busy8, done8}, 32'd0);
    chk("reset2", {27'd0, sum2, cout2, busy2, done2}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 6; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].exp_cout, vecs[i].exp_sum}, $sformatf("vec%0d", i));

    // Random operations against plain arithmetic
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      op8(ra, rb, rc, model, $sformatf("rnd%0d", i));
    end

    // Exhaustive WIDTH=2 sweep
    for (int i = 0; i < 32; i++) begin
      logic [2:0] exp2, prev2;
      int k2;
      a2 = 2'(i >> 3); b2 = 2'(i >> 1); cin2 = 1'(i);
      exp2 = 3'(a2) + 3'(b2) + 3'(cin2);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      prev2 = {cout2, sum2};
      k2 = 0;
      for (int j = 1; j <= 10; j++) begin
        tick();
        if (done2) begin k2 = j; break; end
        if ({cout2, sum2} !== prev2) chk("w2_stable", {29'd0, cout2, sum2}, {29'd0, prev2});
      end
      chk("w2_latency", k2, 2);
      chk("w2_result", {29'd0, cout2, sum2}, {29'd0, exp2});
      $display("op2 a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d", i >> 3, (i >> 1) & 3, i & 1, cout2, sum2);
      tick();
    end

    // start re-pulsed while busy is ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dcount = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3 || i == 8) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      tick();
      if (done8) begin
        dcount++;
        chk("busy_ignore_result", {23'd0, cout8, sum8}, 32'h030);
      end
    end
    start8 = 1'b0;
    chk("busy_ignore_pulses", dcount, 1);
    $display("busy-ignore done_pulses=%0d sum=%02h", dcount, sum8);

    // Reset mid-operation aborts
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", {21'd0, sum8, cout8, busy8, done8}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    $display("abort sum=%02h cout=%0d", sum8, cout8);
    op8(8'h0F, 8'h01, 1'b0, 9'h010, "after_abort");

    // start held high: accepts every 10 edges, done 8 edges after each accept
    start8 = 1'b1;
    for (int e = 0; e < 40; e++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; cin8 = rc;
      hist[e] = {ra, rb, rc};
      tick();
      if (e % 10 == 8) begin
        model = 9'(hist[e-8][16:9]) + 9'(hist[e-8][8:1]) + 9'(hist[e-8][0]);
        chk("b2b_done", {31'd0, done8}, 32'd1);
        chk("b2b_result", {23'd0, cout8, sum8}, {23'd0, model});
        $display("b2b edge=%0d cout=%0d sum=%02h", e, cout8, sum8);
      end else if (done8) begin
        chk("b2b_spurious_done", {31'd0, done8}, 32'd0);
      end
    end
    start8 = 1'b0;
    tick(); tick();
    chk("b2b_idle", {30'd0, busy8, done8}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
